// File: rtl/decoder_hold_n.sv
// Registered N-to-2^N one-hot decoder with a valid/ready input and a fixed HOLD-cycle output pulse.
// Define DECODER_ACTIVE_LOW_EN to make `out_o` active-low (idle all-ones, selected line 0).
module decoder_hold_n #(
    parameter int N    = 2,
    parameter int HOLD = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              in_valid_i,
    input  logic [N-1:0]      in_i,
    output logic              in_ready_o,
    output logic [(1<<N)-1:0] out_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int W  = 1 << N;
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic [W-1:0] IDLE_VAL = '1;
`else
    localparam logic [W-1:0] IDLE_VAL = '0;
`endif

    // state | meaning
    // S_IDLE | output released, may accept a code when enabled
    // S_HOLD | one line driven, counting down the remaining hold cycles
    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t         state_q;
    logic [W-1:0]   out_q;
    logic [CW-1:0]  cnt_q;
    logic           busy_q;
    logic           done_q;
    logic [W-1:0]   onehot;

    assign onehot     = W'(1) << in_i;
    assign in_ready_o = en_i && (state_q == S_IDLE);
    assign out_o      = out_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            out_q   <= IDLE_VAL;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid_i && in_ready_o) begin
                        out_q   <= IDLE_VAL ^ onehot;
                        cnt_q   <= CW'(HOLD - 1);
                        busy_q  <= 1'b1;
                        state_q <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // Losing enable aborts the pulse and wins over normal completion.
                    if (!en_i) begin
                        out_q   <= IDLE_VAL;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (cnt_q == '0) begin
                        out_q   <= IDLE_VAL;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    out_q   <= IDLE_VAL;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_hold_n.sv
// Scoreboard bench for decoder_hold_n (N=2, HOLD=3); expected pulses are queued by the stimulus
// and matched by a monitor that watches the output lines.
module tb_decoder_hold_n;

    localparam int N    = 2;
    localparam int HOLD = 3;
    localparam int W    = 1 << N;

`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic [W-1:0] IDLE_VAL = '1;
`else
    localparam logic [W-1:0] IDLE_VAL = '0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          in_valid;
    logic [N-1:0]  in_code;
    logic          in_ready;
    logic [W-1:0]  out_lines;
    logic          busy;
    logic          done;

    decoder_hold_n #(.N(N), .HOLD(HOLD)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .in_valid_i (in_valid),
        .in_i       (in_code),
        .in_ready_o (in_ready),
        .out_o      (out_lines),
        .busy_o     (busy),
        .done_o     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] pat;
        int           len;
        logic         done;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] onehot, input int len, input logic d);
        exp_t e;
        e.pat  = IDLE_VAL ^ onehot;
        e.len  = len;
        e.done = d;
        return e;
    endfunction

    // Monitor: compares every observed pulse against the scoreboard head.
    logic prev_active = 1'b0;
    exp_t cur;
    int   run = 0;
    always @(negedge clk) begin
        logic active;
        if (rst) begin
            prev_active = 1'b0;
            run = 0;
        end else begin
            active = (out_lines !== IDLE_VAL);
            check("busy_vs_out", {31'b0, busy}, {31'b0, active});
            check("in_ready", {31'b0, in_ready}, {31'b0, en && !active});
            if (active && !prev_active) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got %0h expected none", out_lines);
                    cur = mk('0, 0, 1'b0);
                end else begin
                    cur = sb.pop_front();
                    check("pulse_pattern", {28'b0, out_lines}, {28'b0, cur.pat});
                end
                run = 1;
            end else if (active) begin
                check("pulse_stable", {28'b0, out_lines}, {28'b0, cur.pat});
                run++;
            end else if (prev_active) begin
                check("pulse_len", run, cur.len);
                check("done_at_end", {31'b0, done}, {31'b0, cur.done});
            end else begin
                check("done_idle", {31'b0, done}, 32'd0);
            end
            prev_active = active;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cyc[4];
        int waited;

        rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_code = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", {28'b0, out_lines}, {28'b0, IDLE_VAL});
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_ready_en0", {31'b0, in_ready}, 32'd0);
        rst = 1'b0; en = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {31'b0, in_ready}, 32'd1);

        // Single code 2
        @(posedge clk); #1;
        sb.push_back(mk(4'b0100, HOLD, 1'b1));
        in_code = 2'b10; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("single_out", {28'b0, out_lines}, {28'b0, IDLE_VAL ^ 4'b0100});
        repeat (5) @(posedge clk);

        // All codes back-to-back with in_valid held high
        #1;
        for (int k = 0; k < 4; k++) sb.push_back(mk(W'(1) << k, HOLD, 1'b1));
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_code = N'(k);
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!in_ready && waited < 20);
            if (!in_ready) begin
                checks++; errors++;
                $display("FAIL accept_timeout: got no ready expected ready for code %0d", k);
            end
            acc_cyc[k] = cyc;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int k = 1; k < 4; k++) check("b2b_spacing", acc_cyc[k] - acc_cyc[k-1], HOLD + 1);
        repeat (6) @(posedge clk);

        // Abort: en dropped in the second hold cycle
        #1;
        sb.push_back(mk(4'b0010, 2, 1'b0));
        in_code = 2'b01; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        en = 1'b0;
        @(posedge clk); #1;
        check("abort_out", {28'b0, out_lines}, {28'b0, IDLE_VAL});
        check("abort_done", {31'b0, done}, 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("abort_ready_low", {31'b0, in_ready}, 32'd0);
        end

        // in_valid with en low: no acceptance
        in_valid = 1'b1; in_code = 2'b11;
        repeat (4) @(posedge clk);
        #1;
        check("en0_no_accept", {28'b0, out_lines}, {28'b0, IDLE_VAL});
        in_valid = 1'b0; en = 1'b1;
        @(negedge clk);
        check("ready_en_back", {31'b0, in_ready}, 32'd1);

        // Asynchronous reset in the middle of a hold
        @(posedge clk); #1;
        sb.push_back(mk(4'b0100, HOLD, 1'b1));
        in_code = 2'b10; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #3;
        check("pre_rst_out", {28'b0, out_lines}, {28'b0, IDLE_VAL ^ 4'b0100});
        rst = 1'b1;
        #1;
        check("midrst_out", {28'b0, out_lines}, {28'b0, IDLE_VAL});
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_midrst", {31'b0, in_ready}, 32'd1);

        repeat (6) @(posedge clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder_hold_n.md
# decoder_hold_n

Parametrised, registered N-to-2^N one-hot decoder with a valid/ready input handshake and a programmable hold time. An accepted select code drives exactly one output line active for HOLD clock cycles, then releases it and pulses `done`. It generalises the combinational 2-to-4 decoder to any select width and adds timing behaviour. It sits between a control FSM and strobe or enable lines that need a guaranteed minimum pulse width.

## Interface
- `N`, default 2: select width; output width is 2^N; N ≥ 1.
- `HOLD`, default 4: cycles the decoded line stays active; HOLD ≥ 1.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: block enable; low aborts any active hold and blocks acceptance.
- `in_valid` input 1: `in` holds a code to decode.
- `in` input N: select code.
- `in_ready` output 1: block can accept a code; `in_ready = en && (state == IDLE)`.
- `out` output 2^N: registered decoded lines.
- `busy` output 1: high while in HOLD.
- `done` output 1: registered one-cycle pulse after a hold completes normally.

## Operation
- Two states: IDLE and HOLD, plus a down-counter of width clog2(HOLD) (minimum 1 bit).
- Reset values: state is IDLE; `out`, `busy`, `done` and the counter are all 0.
- **IDLE:**
  - `out` is 0.
  - On a handshake (`in_valid && in_ready`) at an edge:
    - `out` becomes one-hot, with bit `in` set and all others 0.
    - The counter loads HOLD-1.
    - State moves to HOLD.
  - `in` values are all legal, so every code maps to exactly one line.
- **HOLD:** `out` stays constant, `busy` = 1, `in_ready` = 0, and `in`/`in_valid` are ignored.
  - If the counter ≠ 0 and `en` = 1, the counter decrements.
  - If the counter = 0 and `en` = 1: `out` becomes 0, `done` is set to 1 for one cycle, and state moves to IDLE.
  - If `en` = 0 (abort, which takes priority over completion): `out` becomes 0, `done` stays 0, and state moves to IDLE.
- `done` clears on the next edge unconditionally.
- Mid-operation reset: all registers return to reset values immediately, without waiting for a clock edge.

## Timing
- Latency: a handshake at edge t0 makes `out` valid starting at edge t0 and holding through the cycle ending at edge t0+HOLD. At edge t0+HOLD, `out` returns to 0 and `done` rises. So exactly HOLD cycles of active output.
- `busy` covers the same HOLD cycles as active `out`.
- `in_ready` returns high in the cycle after the hold ends, which is the same cycle `done` is high.
- Back-to-back: the earliest next acceptance is edge t0+HOLD+1. This gives at least one idle cycle between pulses.
- HOLD = 1: the counter loads 0, so `out` is active for one cycle and `done` follows.
- No combinational path exists from `in` to `out`.

## Configuration
- Macro `DECODER_ACTIVE_LOW_EN`.
- **Defined:** `out` is active-low.
  - Reset and idle value is all-ones.
  - The selected line is 0 during HOLD.
  - `busy`, `done` and `in_ready` keep their polarity.
- **Undefined:** active-high, as described above.

## Test plan
All scenarios use N=2, HOLD=3.
- Reset asserted mid-HOLD with `out`=4'b0100 → `out`=0, `busy`=0 and `done`=0 immediately; `in_ready`=1 after release with `en`=1.
- `in`=2'b10 accepted at edge t0 → `out`=4'b0100 for 3 cycles; at t0+3 `out`=0 and `done`=1 for exactly one cycle.
- All codes 0–3 sent back-to-back with `in_valid` held high → `out` sequence 0001, 0010, 0100, 1000, each held 3 cycles with one gap cycle; `in_ready` low during every hold.
- `en` dropped in the second hold cycle → `out`=0 on the next edge, `done` never pulses, `in_ready` stays low until `en` returns.
- `in_valid`=1 with `en`=0 in IDLE → no acceptance; `out` remains 0.
- Build with `DECODER_ACTIVE_LOW_EN` and `in`=2'b01 → idle `out`=4'b1111, hold `out`=4'b1101 for 3 cycles.
